ws2812_receiver: RTL and testbench

WS2812_RECEIVER -- requirements
Module: ws2812_receiver

---
 rtl/led_controller_defs.sv | 23 ++
 rtl/ws2812_bit_sync.sv | 25 ++
 rtl/ws2812_receiver.sv | 177 +++++++++++++++++
 tb/tb_ws2812_receiver.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_controller_defs.sv
// Shared LED-controller definitions: pixel type, default WS2812 timing and receiver states.
package led_controller_defs;

  typedef logic [23:0] pixel_t;

  localparam int DEF_ARRAY_LENGTH  = 400;
  localparam int DEF_BIT_THRESHOLD = 60;
  localparam int DEF_MAX_HIGH      = 150;
  localparam int DEF_RESET_CYCLES  = 5000;

  typedef enum logic [1:0] {
    ST_WAIT_RESET = 2'd0,
    ST_IDLE       = 2'd1,
    ST_HIGH       = 2'd2,
    ST_LOW        = 2'd3
  } rx_state_t;

  // Appends one decoded bit to the 23 bits already collected, MSB-first.
  function automatic pixel_t shift_in(input logic [22:0] partial, input logic bit_val);
    return {partial, bit_val};
  endfunction

endpackage

// File: rtl/ws2812_bit_sync.sv
// Two-flop synchronizer bringing the asynchronous LED data line into the clk domain.
module ws2812_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the raw input to resolve metastability.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 serial receiver: measures high/low times of the synchronized line, decodes
// 24-bit pixels MSB-first and reports pixel strobes, frame end and protocol errors.
module ws2812_receiver
  import led_controller_defs::*;
#(
  parameter int ARRAY_LENGTH  = DEF_ARRAY_LENGTH,
  parameter int BIT_THRESHOLD = DEF_BIT_THRESHOLD,
  parameter int MAX_HIGH      = DEF_MAX_HIGH,
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              din,
  output pixel_t                            pixel_data,
  output logic                              pixel_valid,
  output logic [$clog2(ARRAY_LENGTH)-1:0]   pixel_index,
  output logic                              frame_done,
  output logic [$clog2(ARRAY_LENGTH+1)-1:0] pixel_count,
  output logic                              overflow,
  output logic                              error,
  output logic                              busy
);

  localparam int IW = $clog2(ARRAY_LENGTH);
  localparam int CW = $clog2(ARRAY_LENGTH + 1);
  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] THR_LIM  = HW'(BIT_THRESHOLD);
  localparam logic [HW-1:0] HIGH_END = HW'(MAX_HIGH - 1);
  localparam logic [LW-1:0] LOW_END  = LW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] AL_LIM   = CW'(ARRAY_LENGTH);

  logic          din_s;
  logic          bit_val_s;
  pixel_t        word_s;

  rx_state_t     state_q;
  logic [HW-1:0] high_cnt_q;
  logic [LW-1:0] low_cnt_q;
  logic [4:0]    bit_cnt_q;
  logic [22:0]   shift_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  pixel_t        pixel_data_q;
  logic [IW-1:0] pixel_index_q;
  logic [CW-1:0] pixel_count_q;
  logic          pixel_valid_q;
  logic          frame_done_q;
  logic          overflow_q;
  logic          error_q;

  ws2812_bit_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (din_s)
  );

  assign bit_val_s = (high_cnt_q > THR_LIM);
  assign word_s    = shift_in(shift_q, bit_val_s);

  // Receiver FSM: line timing, bit/pixel assembly and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_WAIT_RESET;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= 5'd0;
      shift_q       <= 23'd0;
      idx_q         <= '0;
      cnt_q         <= '0;
      pixel_data_q  <= 24'd0;
      pixel_index_q <= '0;
      pixel_count_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
      case (state_q)
        ST_WAIT_RESET: begin
          if (din_s) begin
            low_cnt_q <= '0;
          end else if (low_cnt_q == LOW_END) begin
            low_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            low_cnt_q <= low_cnt_q + LW'(1);
          end
        end
        ST_IDLE: begin
          // Line is known low here, so any high level is the frame's first rising edge.
          if (din_s) begin
            high_cnt_q <= HW'(1);
            low_cnt_q  <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_HIGH;
          end else begin
            low_cnt_q <= '0;
          end
        end
        ST_HIGH: begin
          if (din_s) begin
            if (high_cnt_q == HIGH_END) begin
              error_q    <= 1'b1;
              high_cnt_q <= '0;
              low_cnt_q  <= '0;
              bit_cnt_q  <= 5'd0;
              shift_q    <= 23'd0;
              idx_q      <= '0;
              cnt_q      <= '0;
              overflow_q <= 1'b0;
              state_q    <= ST_WAIT_RESET;
            end else begin
              high_cnt_q <= high_cnt_q + HW'(1);
            end
          end else begin
            low_cnt_q <= LW'(1);
            state_q   <= ST_LOW;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q <= 5'd0;
              shift_q   <= 23'd0;
              if (idx_q < AL_LIM) begin
                pixel_data_q  <= word_s;
                pixel_index_q <= IW'(idx_q);
                pixel_valid_q <= 1'b1;
                idx_q         <= idx_q + CW'(1);
                cnt_q         <= cnt_q + CW'(1);
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              shift_q   <= word_s[22:0];
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        ST_LOW: begin
          if (din_s) begin
            high_cnt_q <= HW'(1);
            low_cnt_q  <= '0;
            state_q    <= ST_HIGH;
          end else if (low_cnt_q == LOW_END) begin
            frame_done_q  <= 1'b1;
            pixel_count_q <= cnt_q;
            error_q       <= (bit_cnt_q != 5'd0);
            bit_cnt_q     <= 5'd0;
            shift_q       <= 23'd0;
            idx_q         <= '0;
            cnt_q         <= '0;
            low_cnt_q     <= '0;
            state_q       <= ST_IDLE;
          end else begin
            low_cnt_q <= low_cnt_q + LW'(1);
          end
        end
        default: begin
          state_q <= ST_WAIT_RESET;
        end
      endcase
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign overflow    = overflow_q;
  assign error       = error_q;
  assign busy        = (state_q == ST_HIGH) || (state_q == ST_LOW);

endmodule

// File: tb/tb_ws2812_receiver.sv
// Scoreboard bench for ws2812_receiver with scaled-down timing so full frames stay short.
module tb_ws2812_receiver;

  localparam int AL = 4;
  localparam int BT = 6;
  localparam int MH = 15;
  localparam int RC = 50;
  localparam int T0H = 4;
  localparam int T1H = 8;
  localparam int TBIT = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [1:0]  pixel_index;
  logic        frame_done;
  logic [2:0]  pixel_count;
  logic        overflow;
  logic        error;
  logic        busy;

  typedef struct { logic [1:0] idx; logic [23:0] data; } pix_exp_t;
  typedef struct { logic [2:0] cnt; logic err; logic ovf; } frm_exp_t;

  pix_exp_t pix_q[$];
  frm_exp_t frm_q[$];
  pix_exp_t pe;
  frm_exp_t fe;

  int checks = 0;
  int errors = 0;
  int solo_err = 0;
  int cyc_cnt = 0;
  int last_err_cyc = 0;

  ws2812_receiver #(
    .ARRAY_LENGTH (AL),
    .BIT_THRESHOLD(BT),
    .MAX_HIGH     (MH),
    .RESET_CYCLES (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .pixel_count(pixel_count),
    .overflow   (overflow),
    .error      (error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: pop expectations whenever the DUT strobes.
  always @(negedge clk) begin
    if (pixel_valid === 1'b1) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got data=%h index=%0d, required no strobe", pixel_data, pixel_index);
      end else begin
        pe = pix_q.pop_front();
        if (pixel_data !== pe.data || pixel_index !== pe.idx) begin
          errors++;
          $display("FAIL pixel: got data=%h index=%0d, required data=%h index=%0d",
                   pixel_data, pixel_index, pe.data, pe.idx);
        end
      end
    end
    if (frame_done === 1'b1) begin
      checks++;
      if (frm_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got count=%0d, required no strobe", pixel_count);
      end else begin
        fe = frm_q.pop_front();
        if (pixel_count !== fe.cnt || error !== fe.err || overflow !== fe.ovf) begin
          errors++;
          $display("FAIL frame: got count=%0d err=%b ovf=%b, required count=%0d err=%b ovf=%b",
                   pixel_count, error, overflow, fe.cnt, fe.err, fe.ovf);
        end
      end
    end
    if (error === 1'b1 && frame_done !== 1'b1) begin
      solo_err++;
      last_err_cyc = cyc_cnt;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    cyc(b ? T1H : T0H);
    din = 1'b0;
    cyc(b ? (TBIT - T1H) : (TBIT - T0H));
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic idle_low();
    din = 1'b0;
    cyc(RC + 10);
  endtask

  task automatic expect_pix(input logic [1:0] idx, input logic [23:0] data);
    pix_q.push_back('{idx: idx, data: data});
  endtask

  task automatic expect_frm(input logic [2:0] cnt, input logic err, input logic ovf);
    frm_q.push_back('{cnt: cnt, err: err, ovf: ovf});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = 1'b0;
    cyc(5);
    checks++;
    if ({pixel_data, pixel_index, pixel_count} !== 29'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%h index=%0d count=%0d, required 0", pixel_data, pixel_index, pixel_count);
    end
    checks++;
    if ({pixel_valid, frame_done, overflow, error, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {pixel_valid, frame_done, overflow, error, busy});
    end
    rst = 1'b1;
    idle_low();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_single();
    expect_pix(2'd0, 24'h00FF00);
    expect_frm(3'd1, 1'b0, 1'b0);
    send_pixel(24'h00FF00);
    idle_low();
    checks++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d pixels %0d frames outstanding, required 0", pix_q.size(), frm_q.size());
    end
    checks++;
    if (pixel_data !== 24'h00FF00) begin
      errors++;
      $display("FAIL single_hold: got data=%h, required 00ff00", pixel_data);
    end
  endtask

  task automatic test_multi();
    expect_pix(2'd0, 24'h123456);
    expect_pix(2'd1, 24'hABCDEF);
    expect_pix(2'd2, 24'h000001);
    expect_frm(3'd3, 1'b0, 1'b0);
    send_pixel(24'h123456);
    send_pixel(24'hABCDEF);
    send_pixel(24'h000001);
    idle_low();
    expect_pix(2'd0, 24'h5A5A5A);
    expect_frm(3'd1, 1'b0, 1'b0);
    send_pixel(24'h5A5A5A);
    idle_low();
    checks++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      errors++;
      $display("FAIL multi_drain: got %0d pixels %0d frames outstanding, required 0", pix_q.size(), frm_q.size());
    end
  endtask

  task automatic test_partial();
    int s0;
    logic [23:0] p;
    s0 = solo_err;
    p = 24'hFFF000;
    expect_frm(3'd0, 1'b1, 1'b0);
    for (int i = 23; i >= 12; i--) send_bit(p[i]);
    idle_low();
    checks++;
    if (frm_q.size() != 0 || solo_err != s0) begin
      errors++;
      $display("FAIL partial: got %0d frames outstanding, %0d stray errors, required 0 and 0", frm_q.size(), solo_err - s0);
    end
  endtask

  task automatic test_stuck();
    int s0;
    int c0;
    s0 = solo_err;
    din = 1'b1;
    c0 = cyc_cnt;
    cyc(20);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stuck_busy: got %b, required 0", busy);
    end
    send_pixel(24'hF0F0F0);
    idle_low();
    checks++;
    if (solo_err != s0 + 1) begin
      errors++;
      $display("FAIL stuck_error_count: got %0d, required 1", solo_err - s0);
    end
    checks++;
    if (last_err_cyc - c0 != MH + 2) begin
      errors++;
      $display("FAIL stuck_error_time: got %0d cycles, required %0d", last_err_cyc - c0, MH + 2);
    end
    expect_pix(2'd0, 24'h00F00F);
    expect_frm(3'd1, 1'b0, 1'b0);
    send_pixel(24'h00F00F);
    idle_low();
    checks++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      errors++;
      $display("FAIL stuck_drain: got %0d pixels %0d frames outstanding, required 0", pix_q.size(), frm_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [23:0] p;
    for (int i = 0; i < AL + 1; i++) begin
      p = 24'h100000 * (i + 1) + 24'h000003 * i;
      if (i < AL) expect_pix(i[1:0], p);
      if (i == AL) expect_frm(3'd4, 1'b0, 1'b1);
      send_pixel(p);
    end
    idle_low();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold: got %b, required 1", overflow);
    end
    p = 24'h800001;
    expect_pix(2'd0, p);
    expect_frm(3'd1, 1'b0, 1'b0);
    din = 1'b1;
    cyc(4);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b, required 0", overflow);
    end
    cyc(T1H - 4);
    din = 1'b0;
    cyc(TBIT - T1H);
    for (int i = 22; i >= 0; i--) send_bit(p[i]);
    idle_low();
    checks++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      errors++;
      $display("FAIL overflow_drain: got %0d pixels %0d frames outstanding, required 0", pix_q.size(), frm_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] p;
    p = 24'hABCDEF;
    for (int i = 23; i >= 14; i--) send_bit(p[i]);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b, required 1", busy);
    end
    rst = 1'b0;
    cyc(3);
    checks++;
    if ({pixel_data, pixel_index, pixel_count, overflow, busy} !== 31'd0) begin
      errors++;
      $display("FAIL mid_reset: got data=%h index=%0d count=%0d ovf=%b busy=%b, required 0",
               pixel_data, pixel_index, pixel_count, overflow, busy);
    end
    rst = 1'b1;
    for (int i = 13; i >= 0; i--) send_bit(p[i]);
    send_pixel(24'h111111);
    idle_low();
    expect_pix(2'd0, 24'h0F0F0F);
    expect_frm(3'd1, 1'b0, 1'b0);
    send_pixel(24'h0F0F0F);
    idle_low();
    checks++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drain: got %0d pixels %0d frames outstanding, required 0", pix_q.size(), frm_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_partial();
    test_stuck();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
